// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions for the receive and transmit sides.
//   - uart_state_t : frame-level states (IDLE, START, DATA, STOP)
//   - bit_period   : clock cycles per serial bit, CLK_HZ/BAUD truncated
//   - half_period  : half of the bit period, used to reach mid-bit sampling
//   - counter_width: bits needed for a down-counter that starts at DIV-1
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned bit_period(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned baud);
    return bit_period(clk_hz, baud) / 2;
  endfunction

  // The counter never holds more than div-1, so $clog2(div) bits suffice.
  function automatic int unsigned counter_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk : sampling clock
//   rst : synchronous active-high reset, both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with mid-bit sampling.
//   Parameters: CLK_HZ (system clock in Hz), BAUD (serial bit rate)
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   recv_data  : last correctly received byte (held until the next good byte)
//   recv_valid : one-cycle pulse when recv_data has just been updated
//   frame_err  : one-cycle pulse when the stop bit was sampled low
//   busy       : high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV   = bit_period(CLK_HZ, BAUD);
  localparam int unsigned HALF  = half_period(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = counter_width(DIV);

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_next;
  logic             valid_next, ferr_next;
  logic             rx_s, rx_prev;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Starts are edge-triggered rather than level-triggered, so a line held
  // low after a framing error (a break) cannot restart reception until it
  // has gone high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      recv_data  <= 8'h00;
      recv_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_prev    <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= idx_next;
      shift_reg  <= shift_next;
      recv_data  <= data_next;
      recv_valid <= valid_next;
      frame_err  <= ferr_next;
      rx_prev    <= rx_s;
    end
  end

  // The START wait of HALF cycles lands every later sample at mid-bit.
  // Leaving STOP at its mid-point gives half a bit of slack for a
  // back-to-back start bit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    data_next  = recv_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          cnt_next   = CNT_HALF;
          state_next = START;
        end
      end

      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            cnt_next   = CNT_BIT;
            idx_next   = 3'd0;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_s, shift_reg[7:1]};
          cnt_next   = CNT_BIT;
          idx_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      STOP: begin
        if (cnt == '0) begin
          state_next = IDLE;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The DUT runs at 50 MHz / 115200 baud
// (DIV = 434, HALF = 217) to keep the run short while leaving room for
// a 200-cycle glitch shorter than half a bit.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int DIV  = 434;
  localparam int HALF = 217;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       frame_err;
  logic       busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit check_en     = 1'b0;

  // Counts of output pulses seen on the DUT, plus the bytes it delivered.
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  logic [7:0] got_bytes[$];

  // Reference model state: what the outputs must be after each edge.
  bit         m_active = 1'b0;
  int         m_age    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [7:0] m_data   = 8'h00;
  bit         m_valid  = 1'b0;
  bit         m_ferr   = 1'b0;
  bit         h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .recv_data  (recv_data),
    .recv_valid (recv_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // 100 MHz-style 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The receiver sees the line two clocks late and acts
  // one clock after that, so decisions at this edge use the line value
  // from two edges back (and the one before for edge detection). Once a
  // falling edge starts a frame, samples fall at fixed ages: HALF for the
  // start bit, HALF + k*DIV for data bits k=1..8 and the stop bit at k=9.
  always @(posedge clk) begin : model
    bit v, vp;
    int k;
    v  = h1;
    vp = h2;
    h2 = h1;
    h1 = h0;
    h0 = rx;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_age    = 0;
      m_data   = 8'h00;
      h0 = 1'b1;
      h1 = 1'b1;
      h2 = 1'b1;
    end else if (!m_active) begin
      if (!v && vp) begin
        m_active = 1'b1;
        m_age    = 0;
      end
    end else begin
      m_age++;
      if (m_age == HALF) begin
        if (v) m_active = 1'b0;
      end else if (m_age > HALF && ((m_age - HALF) % DIV) == 0) begin
        k = (m_age - HALF) / DIV;
        if (k <= 8) begin
          m_byte[k-1] = v;
        end else begin
          m_active = 1'b0;
          if (v) begin
            m_data  = m_byte;
            m_valid = 1'b1;
          end else begin
            m_ferr = 1'b1;
          end
        end
      end
    end
  end

  // Every cycle: compare DUT outputs with the model and tally pulses.
  always @(negedge clk) begin
    if (check_en) begin
      n_compared++;
      if (recv_valid !== m_valid || frame_err !== m_ferr ||
          recv_data !== m_data || busy !== m_active) begin
        n_mismatched++;
        $display("[TB] FAIL model_cycle @%0t: valid/ferr/data/busy got %b/%b/%h/%b expected %b/%b/%h/%b",
                 $time, recv_valid, frame_err, recv_data, busy,
                 m_valid, m_ferr, m_data, m_active);
      end
      n_compared++;
      if (recv_valid === 1'b1 && frame_err === 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL pulse_exclusive @%0t: valid and frame_err both 1, expected at most one",
                 $time);
      end
      if (recv_valid === 1'b1) begin
        valid_cnt++;
        got_bytes.push_back(recv_data);
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  // Literal comparison helper.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Hold the line at a level for a number of clocks; entered and left at
  // 1 time unit after a rising edge so stimulus never races the DUT.
  task automatic hold_line(input logic level, input int cycles);
    rx = level;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Send one 8N1 frame, LSB first, with a selectable stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_level);
    hold_line(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold_line(data[i], DIV);
    hold_line(stop_level, DIV);
  endtask

  initial begin
    int v0, f0, n;
    bit seen;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state and the package's bit-period derivation at defaults.
    checkOutput("reset_data",  recv_data, 8'h00);
    checkOutput("reset_valid", recv_valid, 1'b0);
    checkOutput("reset_ferr",  frame_err, 1'b0);
    checkOutput("reset_busy",  busy, 1'b0);
    checkOutput("pkg_div_default",  bit_period(100_000_000, 115_200), 868);
    checkOutput("pkg_half_default", half_period(100_000_000, 115_200), 434);
    hold_line(1'b1, 20);

    // Clean 0x55 frame.
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h55, 1'b1);
    checkOutput("b55_valid_count", valid_cnt - v0, 1);
    checkOutput("b55_ferr_count",  ferr_cnt - f0, 0);
    checkOutput("b55_data",        recv_data, 8'h55);
    checkOutput("b55_busy_after",  busy, 1'b0);
    hold_line(1'b1, 50);

    // 200-cycle glitch: busy must drop HALF+2 clocks after the first edge
    // that samples the line low, with no output pulse.
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 199) rx = 1'b1;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    checkOutput("glitch_busy_low_cycles", n, HALF + 2);
    hold_line(1'b1, 50);
    checkOutput("glitch_valid_count", valid_cnt - v0, 0);
    checkOutput("glitch_ferr_count",  ferr_cnt - f0, 0);

    // Good 0x3C, then 0xA3 with a low stop bit.
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'h3C, 1'b1);
    hold_line(1'b1, 50);
    applyStimulus(8'hA3, 1'b0);
    hold_line(1'b1, DIV);
    checkOutput("ferr_valid_count", valid_cnt - v0, 1);
    checkOutput("ferr_ferr_count",  ferr_cnt - f0, 1);
    checkOutput("ferr_data_kept",   recv_data, 8'h3C);

    // Back-to-back 0xA3 then 0x0F with no idle gap.
    v0 = valid_cnt; f0 = ferr_cnt;
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h0F, 1'b1);
    hold_line(1'b1, 50);
    checkOutput("b2b_valid_count", valid_cnt - v0, 2);
    checkOutput("b2b_ferr_count",  ferr_cnt - f0, 0);
    if (got_bytes.size() >= 2) begin
      checkOutput("b2b_first",  got_bytes[got_bytes.size()-2], 8'hA3);
      checkOutput("b2b_second", got_bytes[got_bytes.size()-1], 8'h0F);
    end else begin
      checkOutput("b2b_byte_log_size", got_bytes.size(), 2);
    end

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x81.
    v0 = valid_cnt; f0 = ferr_cnt;
    hold_line(1'b0, DIV);
    for (int i = 0; i < 4; i++) hold_line(1'b1, DIV);
    hold_line(1'b1, DIV / 2);
    rst = 1'b1;
    hold_line(1'b1, 3);
    rst = 1'b0;
    checkOutput("midreset_data", recv_data, 8'h00);
    checkOutput("midreset_busy", busy, 1'b0);
    hold_line(1'b1, DIV * 6);
    checkOutput("midreset_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    applyStimulus(8'h81, 1'b1);
    hold_line(1'b1, 50);
    checkOutput("b81_valid_count", valid_cnt - v0, 1);
    checkOutput("b81_ferr_count",  ferr_cnt - f0, 0);
    checkOutput("b81_data",        recv_data, 8'h81);

    // Break: line low for 20 bit times, then high, then 0x12.
    v0 = valid_cnt; f0 = ferr_cnt;
    hold_line(1'b0, DIV * 20);
    hold_line(1'b1, DIV);
    checkOutput("break_ferr_count",  ferr_cnt - f0, 1);
    checkOutput("break_valid_count", valid_cnt - v0, 0);
    applyStimulus(8'h12, 1'b1);
    hold_line(1'b1, 50);
    checkOutput("b12_valid_count", valid_cnt - v0, 1);
    checkOutput("b12_ferr_count",  ferr_cnt - f0, 1);
    checkOutput("b12_data",        recv_data, 8'h12);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz PLL output); all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line from USB-serial chip; idle high.
REQ-006 SHALL have port recv_data  output  8  last correctly received byte.
REQ-007 SHALL have port recv_valid  output  1  one-cycle pulse, recv_data newly valid.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s), both flops reset to 1; all decisions use rx_s only.
REQ-011 SHALL use bit period DIV = CLK_HZ/BAUD, integer truncated (868 at defaults), and half period HALF = DIV/2 (434).
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a down-counter sized for DIV-1 and a 3-bit bit index.
REQ-013 IDLE: on rx_s==0 with previous rx_s==1 (falling edge), SHALL load counter with HALF-1 and enter START.
REQ-014 START: on counter==0, SHALL enter DATA (counter=DIV-1, index=0) if rx_s==0, else return to IDLE with no output pulse (glitch reject).
REQ-015 DATA: on each counter==0, SHALL shift rx_s into shift register LSB-first, reload DIV-1; after index 7 enter STOP.
REQ-016 STOP: on counter==0 with rx_s==1, SHALL load recv_data from shift register, pulse recv_valid next cycle, enter IDLE.
REQ-017 STOP: on counter==0 with rx_s==0, SHALL pulse frame_err, keep recv_data unchanged, enter IDLE.
REQ-018 After a framing error SHALL require a rising edge on rx_s before a new start is accepted (a held-low break yields exactly one frame_err).
REQ-019 recv_valid and frame_err SHALL never be asserted in the same cycle and SHALL each last exactly one cycle.
REQ-020 Return to IDLE at mid-stop SHALL allow a back-to-back start bit immediately following the stop bit to be accepted.
REQ-021 No backpressure: a consumer not sampling recv_valid loses the byte; recv_data holds until the next good byte.

Reset
REQ-022 On rst high at a clock edge: state=IDLE, counter=0, index=0, shift register=0, recv_data=8'h00, recv_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abandon the frame without any pulse; reception resumes at the next falling edge after rst drops.

Structure
REQ-024 State encoding and the DIV/HALF derivation SHALL live in a shared package used also by the transmit side.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff (reset value parameterized, here 1).

Verification
REQ-026 Send 0x55 at 115200, 8N1 -> exactly one recv_valid, recv_data=0x55, frame_err never high, busy low after stop mid-point.
REQ-027 Low pulse of 200 cycles on idle line -> no recv_valid, no frame_err, busy returns low 434+2 cycles after the falling edge.
REQ-028 Send 0xA3 with stop bit driven low after prior good 0x3C -> one frame_err, recv_data stays 0x3C.
REQ-029 Back-to-back 0xA3 then 0x0F with no idle gap -> two recv_valid pulses, data 0xA3 then 0x0F.
REQ-030 Assert rst during bit 4 of 0xFF, release, then send 0x81 -> no pulse for the aborted frame, then recv_data=0x81 with one recv_valid.
REQ-031 Hold rx low for 20 bit times, then high, then send 0x12 -> exactly one frame_err, then recv_data=0x12 with one recv_valid.
